ex_stage: RTL and testbench
===========================

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width in bits (legal >= 32).
REQ-002 SHALL have parameter IMM_W, default 16, immediate width (legal <= DATA_W/2).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operation offered.
REQ-006 SHALL have port in_ready  output  1  operation accepted when in_valid&in_ready.
REQ-007 SHALL have ports alu_mode, use_reg, set_flags  input  1 each  ALU class, op2-vs-imm select, flag-write enable.
REQ-008 SHALL have ports op  input  3  opcode; cond  input  4  branch condition.
REQ-009 SHALL have ports op1, op2  input  DATA_W  operands; imm  input  IMM_W  immediate.
REQ-010 SHALL have ports out_valid  output  1  result held; out_ready  input  1  consumer takes result.
REQ-011 SHALL have ports result  output  DATA_W; branch_taken  output  1; flags  output  4  registered {N,C,Z,V}; busy  output  1  multi-cycle op running.

Function
REQ-012 SHALL sign-extend imm to DATA_W; operand B = use_reg ? op2 : sext(imm).
REQ-013 alu_mode=1 SHALL decode op: 001 ADD, 010 SUB (A-B), 011 AND, 100 OR, 101 XOR, 110 NOT A; 000/111 pass A.
REQ-014 alu_mode=0 SHALL decode op: 000 MOV sext(imm), 001 MOVT {imm at [31:16], op1 elsewhere}, 010 CLR 0, 011 SET all-ones, 100 LSL, 101 LSR, 110 BCOND, 111 B.
REQ-015 Shift amount SHALL be imm[clog2(DATA_W)..0]; amount >= DATA_W SHALL yield 0; amount 0 yields op1.
REQ-016 BCOND SHALL set branch_taken = cond_eval(cond, flags) with result 0; B SHALL set branch_taken=1; all other ops branch_taken=0.
REQ-017 Conditions SHALL be 0 EQ Z, 1 NE, 2 CS C, 3 CC, 4 MI N, 5 PL, 6 VS V, 7 VC, 8 HI C&!Z, 9 LS, A GE N==V, B LT, C GT !Z&(N==V), D LE, E AL, F NV (never).
REQ-018 When alu_mode&set_flags, flags SHALL update with result: N=msb, Z=(result==0), ADD C=carry-out, V=signed overflow; SUB C=no-borrow (A>=B unsigned), V=signed overflow; logic/NOT/pass C=0, V=0.
REQ-019 Flags SHALL NOT change for alu_mode=0 or set_flags=0.
REQ-020 in_ready SHALL equal !busy & (!out_valid | out_ready).
REQ-021 Single-cycle ops SHALL load result/branch_taken/flags at the accepting edge; out_valid=1 next cycle (latency 1).
REQ-022 An op accepted after a flag-setting op SHALL evaluate BCOND against the updated flags (no stale-flag hazard).
REQ-023 out_valid SHALL stay high and result stable until out_ready; simultaneous consume and accept SHALL reload back-to-back without a bubble.
REQ-024 Iterative shift (see REQ-028) SHALL hold busy=1, in_ready=0 until complete, then assert out_valid.

Reset
REQ-025 rst SHALL clear out_valid, busy, branch_taken, result, flags to 0 and shift counter to 0 on the next edge.
REQ-026 rst mid-shift SHALL abort the shift; no result delivered; in_ready=1 the cycle after reset releases.

Configuration
REQ-027 Macro EX_BARREL_SHIFT_EN defined: LSL/LSR SHALL complete in one cycle like other ops, busy never asserts.
REQ-028 EX_BARREL_SHIFT_EN undefined: shift SHALL proceed 1 bit per cycle; latency = min(amount, DATA_W)+1 cycles; amount 0 latency 1.

Structure
REQ-029 Package ex_pkg SHALL hold opcode constants, condition-code constants and flag bit indices (N=3,C=2,Z=1,V=0).
REQ-030 Condition evaluation SHALL be sub-module ex_cond_eval (combinational, cond+flags -> taken).

Verification
REQ-031 ADD use_reg, set_flags, op1=0x7FFFFFFF, op2=1 -> result 0x80000000, flags N=1,C=0,Z=0,V=1, out_valid after 1 cycle.
REQ-032 SUB imm, op1=5, imm=5, set_flags, then BCOND cond=0 -> Z=1,C=1; branch_taken=1; cond=1 -> 0.
REQ-033 LSL op1=1, imm=4, macro off -> busy 4 cycles, in_ready=0, result 0x10 on cycle 5; imm=40 -> result 0.
REQ-034 out_ready held 0 for 3 cycles with result 0xA5 -> result stable, in_ready=0; out_ready=1 with new in_valid -> back-to-back accept.
REQ-035 rst asserted on cycle 2 of 8-bit LSR -> out_valid=0, flags 0, busy=0 next cycle.
REQ-036 MOVT op1=0x00001234, imm=0xBEEF -> 0xBEEF1234, flags unchanged.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared constants for the execute stage: opcodes for both ALU classes,
// branch condition codes, flag bit positions and a flag packing helper.
package ex_pkg;

  // alu_mode = 1 opcodes
  localparam logic [2:0] ALU_PASS  = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_XOR   = 3'b101;
  localparam logic [2:0] ALU_NOT   = 3'b110;
  localparam logic [2:0] ALU_PASS2 = 3'b111;

  // alu_mode = 0 opcodes
  localparam logic [2:0] OP_MOV    = 3'b000;
  localparam logic [2:0] OP_MOVT   = 3'b001;
  localparam logic [2:0] OP_CLR    = 3'b010;
  localparam logic [2:0] OP_SET    = 3'b011;
  localparam logic [2:0] OP_LSL    = 3'b100;
  localparam logic [2:0] OP_LSR    = 3'b101;
  localparam logic [2:0] OP_BCOND  = 3'b110;
  localparam logic [2:0] OP_B      = 3'b111;

  // Branch condition codes
  localparam logic [3:0] CC_EQ = 4'h0;
  localparam logic [3:0] CC_NE = 4'h1;
  localparam logic [3:0] CC_CS = 4'h2;
  localparam logic [3:0] CC_CC = 4'h3;
  localparam logic [3:0] CC_MI = 4'h4;
  localparam logic [3:0] CC_PL = 4'h5;
  localparam logic [3:0] CC_VS = 4'h6;
  localparam logic [3:0] CC_VC = 4'h7;
  localparam logic [3:0] CC_HI = 4'h8;
  localparam logic [3:0] CC_LS = 4'h9;
  localparam logic [3:0] CC_GE = 4'hA;
  localparam logic [3:0] CC_LT = 4'hB;
  localparam logic [3:0] CC_GT = 4'hC;
  localparam logic [3:0] CC_LE = 4'hD;
  localparam logic [3:0] CC_AL = 4'hE;
  localparam logic [3:0] CC_NV = 4'hF;

  // Flag bit positions inside the 4-bit flags vector
  localparam int FLAG_N = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 0;

  // Direction of the iterative shifter
  typedef enum logic {
    SHIFT_RIGHT = 1'b0,
    SHIFT_LEFT  = 1'b1
  } shift_dir_e;

  // Place individual flag bits at their defined positions
  function automatic logic [3:0] pack_flags(input logic n, input logic c,
                                            input logic z, input logic v);
    logic [3:0] f;
    f         = 4'b0000;
    f[FLAG_N] = n;
    f[FLAG_C] = c;
    f[FLAG_Z] = z;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/ex_cond_eval.sv
// Combinational branch condition evaluator: cond + {N,C,Z,V} -> taken.
import ex_pkg::*;

module ex_cond_eval (
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);

  logic n;
  logic c;
  logic z;
  logic v;

  assign n = flags[FLAG_N];
  assign c = flags[FLAG_C];
  assign z = flags[FLAG_Z];
  assign v = flags[FLAG_V];

  // Decode the condition code against the current flags
  always_comb begin
    taken = 1'b0;
    case (cond)
      CC_EQ:   taken = z;
      CC_NE:   taken = !z;
      CC_CS:   taken = c;
      CC_CC:   taken = !c;
      CC_MI:   taken = n;
      CC_PL:   taken = !n;
      CC_VS:   taken = v;
      CC_VC:   taken = !v;
      CC_HI:   taken = c && !z;
      CC_LS:   taken = !c || z;
      CC_GE:   taken = (n == v);
      CC_LT:   taken = (n != v);
      CC_GT:   taken = !z && (n == v);
      CC_LE:   taken = z || (n != v);
      CC_AL:   taken = 1'b1;
      CC_NV:   taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, move/constant ops, shifts and branch resolution with a
// valid/ready handshake on both sides and registered result/flags.
// Configuration macro EX_BARREL_SHIFT_EN: when defined, LSL/LSR complete in a
// single cycle; when undefined, shifts iterate one bit per cycle with busy high.
import ex_pkg::*;

module ex_stage #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              alu_mode,
  input  logic              use_reg,
  input  logic              set_flags,
  input  logic [2:0]        op,
  input  logic [3:0]        cond,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  input  logic [IMM_W-1:0]  imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              branch_taken,
  output logic [3:0]        flags,
  output logic              busy
);

  localparam int MSB  = DATA_W - 1;
  // Shift amount field covers 0 .. 2*DATA_W-1 so over-range amounts are seen
  localparam int SH_W = $clog2(DATA_W) + 1;
  localparam logic [SH_W-1:0] SH_FULL = SH_W'(DATA_W);
  localparam logic [SH_W-1:0] SH_ONE  = SH_W'(1);

  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] opb;
  logic [DATA_W:0]   add_full;
  logic [DATA_W-1:0] sub_res;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic              alu_v;
  logic [3:0]        alu_flags;
  logic [DATA_W-1:0] mov_res;
  logic              mov_taken;
  logic              start_shift;
  logic [DATA_W-1:0] next_res;
  logic              next_taken;
  logic              cond_taken;
  logic              accept;
  logic [SH_W-1:0]   sh_amt;
  logic              sh_over;
  logic [SH_W-1:0]   sh_cnt_init;
  logic [SH_W-1:0]   sh_cnt;
  shift_dir_e        sh_dir;

  assign imm_sext    = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  assign opb         = use_reg ? op2 : imm_sext;
  assign add_full    = {1'b0, op1} + {1'b0, opb};
  assign sub_res     = op1 - opb;
  assign sh_amt      = imm[SH_W-1:0];
  assign sh_over     = (sh_amt >= SH_FULL);
  assign sh_cnt_init = sh_over ? SH_FULL : sh_amt;

  assign in_ready = !busy && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Branches are resolved against the registered flags, which already hold
  // the outcome of any flag-setting op accepted on an earlier edge.
  ex_cond_eval u_cond_eval (
    .cond  (cond),
    .flags (flags),
    .taken (cond_taken)
  );

  // Arithmetic/logic class: result plus carry and overflow
  always_comb begin
    alu_res = op1;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      ALU_ADD: begin
        alu_res = add_full[MSB:0];
        alu_c   = add_full[DATA_W];
        alu_v   = (op1[MSB] == opb[MSB]) && (add_full[MSB] != op1[MSB]);
      end
      ALU_SUB: begin
        alu_res = sub_res;
        alu_c   = (op1 >= opb);
        alu_v   = (op1[MSB] != opb[MSB]) && (sub_res[MSB] != op1[MSB]);
      end
      ALU_AND:   alu_res = op1 & opb;
      ALU_OR:    alu_res = op1 | opb;
      ALU_XOR:   alu_res = op1 ^ opb;
      ALU_NOT:   alu_res = ~op1;
      ALU_PASS:  alu_res = op1;
      ALU_PASS2: alu_res = op1;
      default:   alu_res = op1;
    endcase
  end

  assign alu_flags = pack_flags(alu_res[MSB], alu_c, (alu_res == '0), alu_v);

  // Move / constant / shift / branch class
  always_comb begin
    mov_res     = '0;
    mov_taken   = 1'b0;
    start_shift = 1'b0;
    case (op)
      OP_MOV:  mov_res = imm_sext;
      OP_MOVT: begin
        mov_res        = op1;
        mov_res[31:16] = imm_sext[15:0];
      end
      OP_CLR:  mov_res = '0;
      OP_SET:  mov_res = '1;
`ifdef EX_BARREL_SHIFT_EN
      OP_LSL:  mov_res = sh_over ? '0 : (op1 << sh_amt);
      OP_LSR:  mov_res = sh_over ? '0 : (op1 >> sh_amt);
`else
      OP_LSL, OP_LSR: begin
        // A zero amount finishes at once with op1; otherwise iterate
        mov_res     = op1;
        start_shift = (sh_cnt_init != '0);
      end
`endif
      OP_BCOND: mov_taken = cond_taken;
      OP_B:     mov_taken = 1'b1;
      default: begin
        mov_res   = '0;
        mov_taken = 1'b0;
      end
    endcase
  end

  // Select between the two op classes
  always_comb begin
    if (alu_mode) begin
      next_res   = alu_res;
      next_taken = 1'b0;
    end else begin
      next_res   = mov_res;
      next_taken = mov_taken;
    end
  end

  // Output registers, flag register and the iterative shifter
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      busy         <= 1'b0;
      branch_taken <= 1'b0;
      result       <= '0;
      flags        <= 4'b0000;
      sh_cnt       <= '0;
      sh_dir       <= SHIFT_RIGHT;
    end else if (accept) begin
      branch_taken <= next_taken;
      if (alu_mode && set_flags) begin
        flags <= alu_flags;
      end else begin
        flags <= flags;
      end
      if (start_shift) begin
        // result doubles as the shift working register while busy
        result    <= op1;
        busy      <= 1'b1;
        out_valid <= 1'b0;
        sh_cnt    <= sh_cnt_init;
        sh_dir    <= (op == OP_LSL) ? SHIFT_LEFT : SHIFT_RIGHT;
      end else begin
        result    <= next_res;
        out_valid <= 1'b1;
      end
    end else if (busy) begin
      if (sh_dir == SHIFT_LEFT) begin
        result <= result << 1;
      end else begin
        result <= result >> 1;
      end
      sh_cnt <= sh_cnt - SH_ONE;
      if (sh_cnt == SH_ONE) begin
        busy      <= 1'b0;
        out_valid <= 1'b1;
      end else begin
        busy      <= 1'b1;
        out_valid <= 1'b0;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed, table-driven bench for ex_stage (default build: iterative shifter).
import ex_pkg::*;

module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        alu_mode;
  logic        use_reg;
  logic        set_flags;
  logic [2:0]  op;
  logic [3:0]  cond;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [15:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        branch_taken;
  logic [3:0]  flags;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        am;
    logic        ur;
    logic        sf;
    logic [2:0]  opc;
    logic [3:0]  cc;
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] im;
    logic [31:0] exp_res;
    logic        exp_tk;
    logic [3:0]  exp_fl;
  } vec_t;

  vec_t vecs[$];

  ex_stage #(.DATA_W(32), .IMM_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_mode     (alu_mode),
    .use_reg      (use_reg),
    .set_flags    (set_flags),
    .op           (op),
    .cond         (cond),
    .op1          (op1),
    .op2          (op2),
    .imm          (imm),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .branch_taken (branch_taken),
    .flags        (flags),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic addv(input logic am, input logic ur, input logic sf, input logic [2:0] opc,
                      input logic [3:0] cc, input logic [31:0] a, input logic [31:0] b,
                      input logic [15:0] im, input logic [31:0] er, input logic et,
                      input logic [3:0] ef);
    vec_t v;
    v.am = am; v.ur = ur; v.sf = sf; v.opc = opc; v.cc = cc;
    v.a = a; v.b = b; v.im = im; v.exp_res = er; v.exp_tk = et; v.exp_fl = ef;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic am, input logic ur, input logic sf, input logic [2:0] opc,
                       input logic [3:0] cc, input logic [31:0] a, input logic [31:0] b,
                       input logic [15:0] im);
    alu_mode = am; use_reg = ur; set_flags = sf; op = opc; cond = cc;
    op1 = a; op2 = b; imm = im; in_valid = 1'b1;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  // Issue a shift, track cycles until out_valid, checking busy/in_ready meanwhile
  task automatic run_shift(input string name, input logic [2:0] sop, input logic [31:0] a,
                           input logic [15:0] amt, input logic [31:0] exp_res, input int exp_lat);
    int cyc;
    logic [3:0] fl_before;
    fl_before = flags;
    drive(1'b0, 1'b0, 1'b0, sop, CC_AL, a, 32'h0000_0000, amt);
    out_ready = 1'b1;
    #1;
    chk({name, "_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      chk({name, "_busy"}, {31'd0, busy}, 32'd1);
      chk({name, "_inrdy_low"}, {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      cyc++;
    end
    chk({name, "_latency"}, cyc, exp_lat);
    chk({name, "_res"}, result, exp_res);
    chk({name, "_busy_end"}, {31'd0, busy}, 32'd0);
    chk({name, "_flags"}, {28'd0, flags}, {28'd0, fl_before});
  endtask

  initial begin
    bit seen;

    // am ur sf op cond op1 op2 imm | result taken flags{N,C,Z,V}
    addv(1, 1, 1, ALU_ADD,  CC_EQ, 32'h7FFF_FFFF, 32'h0000_0001, 16'h0000, 32'h8000_0000, 0, 4'b1001);
    addv(1, 0, 1, ALU_SUB,  CC_EQ, 32'h0000_0005, 32'h0000_0000, 16'h0005, 32'h0000_0000, 0, 4'b0110);
    addv(0, 0, 0, OP_BCOND, CC_EQ, 32'h0000_0000, 32'h0000_0000, 16'h0000, 32'h0000_0000, 1, 4'b0110);
    addv(0, 0, 0, OP_BCOND, CC_NE, 32'h0000_0000, 32'h0000_0000, 16'h0000, 32'h0000_0000, 0, 4'b0110);
    addv(0, 0, 0, OP_BCOND, CC_HI, 32'h0000_0000, 32'h0000_0000, 16'h0000, 32'h0000_0000, 0, 4'b0110);
    addv(0, 0, 0, OP_BCOND, CC_LS, 32'h0000_0000, 32'h0000_0000, 16'h0000, 32'h0000_0000, 1, 4'b0110);
    addv(0, 0, 0, OP_BCOND, CC_CS, 32'h0000_0000, 32'h0000_0000, 16'h0000, 32'h0000_0000, 1, 4'b0110);
    addv(1, 1, 1, ALU_ADD,  CC_EQ, 32'h8000_0000, 32'h8000_0000, 16'h0000, 32'h0000_0000, 0, 4'b0111);
    addv(0, 0, 0, OP_BCOND, CC_GE, 32'h0000_0000, 32'h0000_0000, 16'h0000, 32'h0000_0000, 0, 4'b0111);
    addv(0, 0, 0, OP_BCOND, CC_VS, 32'h0000_0000, 32'h0000_0000, 16'h0000, 32'h0000_0000, 1, 4'b0111);
    addv(1, 1, 1, ALU_SUB,  CC_EQ, 32'h0000_0003, 32'h0000_0005, 16'h0000, 32'hFFFF_FFFE, 0, 4'b1000);
    addv(0, 0, 0, OP_BCOND, CC_LT, 32'h0000_0000, 32'h0000_0000, 16'h0000, 32'h0000_0000, 1, 4'b1000);
    addv(0, 0, 0, OP_BCOND, CC_GT, 32'h0000_0000, 32'h0000_0000, 16'h0000, 32'h0000_0000, 0, 4'b1000);
    addv(0, 0, 0, OP_BCOND, CC_LE, 32'h0000_0000, 32'h0000_0000, 16'h0000, 32'h0000_0000, 1, 4'b1000);
    addv(0, 0, 0, OP_BCOND, CC_AL, 32'h0000_0000, 32'h0000_0000, 16'h0000, 32'h0000_0000, 1, 4'b1000);
    addv(0, 0, 0, OP_BCOND, CC_NV, 32'h0000_0000, 32'h0000_0000, 16'h0000, 32'h0000_0000, 0, 4'b1000);
    addv(0, 0, 0, OP_BCOND, CC_MI, 32'h0000_0000, 32'h0000_0000, 16'h0000, 32'h0000_0000, 1, 4'b1000);
    addv(0, 0, 0, OP_BCOND, CC_CC, 32'h0000_0000, 32'h0000_0000, 16'h0000, 32'h0000_0000, 1, 4'b1000);
    addv(1, 1, 1, ALU_AND,  CC_EQ, 32'hF0F0_F0F0, 32'hFF00_FF00, 16'h0000, 32'hF000_F000, 0, 4'b1000);
    addv(1, 1, 0, ALU_OR,   CC_EQ, 32'h0000_000F, 32'h0000_00F0, 16'h0000, 32'h0000_00FF, 0, 4'b1000);
    addv(1, 1, 1, ALU_XOR,  CC_EQ, 32'hAAAA_5555, 32'hAAAA_5555, 16'h0000, 32'h0000_0000, 0, 4'b0010);
    addv(0, 0, 0, OP_BCOND, CC_EQ, 32'h0000_0000, 32'h0000_0000, 16'h0000, 32'h0000_0000, 1, 4'b0010);
    addv(0, 0, 0, OP_BCOND, CC_PL, 32'h0000_0000, 32'h0000_0000, 16'h0000, 32'h0000_0000, 1, 4'b0010);
    addv(1, 1, 1, ALU_NOT,  CC_EQ, 32'h0000_0000, 32'h0000_0000, 16'h0000, 32'hFFFF_FFFF, 0, 4'b1000);
    addv(1, 1, 1, ALU_PASS, CC_EQ, 32'h1234_5678, 32'hFFFF_FFFF, 16'h0000, 32'h1234_5678, 0, 4'b0000);
    addv(1, 1, 1, ALU_PASS2, CC_EQ, 32'h0000_0000, 32'h1111_1111, 16'h0000, 32'h0000_0000, 0, 4'b0010);
    addv(0, 0, 1, OP_MOV,   CC_EQ, 32'h0000_0000, 32'h0000_0000, 16'h8001, 32'hFFFF_8001, 0, 4'b0010);
    addv(0, 0, 1, OP_MOVT,  CC_EQ, 32'h0000_1234, 32'h0000_0000, 16'hBEEF, 32'hBEEF_1234, 0, 4'b0010);
    addv(0, 0, 0, OP_CLR,   CC_EQ, 32'h0000_FFFF, 32'h0000_0000, 16'h0000, 32'h0000_0000, 0, 4'b0010);
    addv(0, 0, 0, OP_SET,   CC_EQ, 32'h0000_0000, 32'h0000_0000, 16'h0000, 32'hFFFF_FFFF, 0, 4'b0010);
    addv(0, 0, 0, OP_B,     CC_NV, 32'h0000_0000, 32'h0000_0000, 16'h0000, 32'h0000_0000, 1, 4'b0010);
    addv(1, 0, 0, ALU_ADD,  CC_EQ, 32'h0000_0010, 32'h0000_0000, 16'hFFFF, 32'h0000_000F, 0, 4'b0010);
    addv(0, 0, 0, OP_LSL,   CC_EQ, 32'h0000_ABCD, 32'h0000_0000, 16'h0000, 32'h0000_ABCD, 0, 4'b0010);
    addv(1, 1, 1, ALU_SUB,  CC_EQ, 32'h8000_0000, 32'h0000_0001, 16'h0000, 32'h7FFF_FFFF, 0, 4'b0101);
    addv(1, 0, 1, ALU_SUB,  CC_EQ, 32'h0000_0000, 32'h0000_0000, 16'h0001, 32'hFFFF_FFFF, 0, 4'b1000);

    // Reset and reset-state checks
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    drive(1'b0, 1'b0, 1'b0, OP_MOV, CC_EQ, 32'h0, 32'h0, 16'h0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {28'd0, flags}, 32'd0);
    chk("rst_taken", {31'd0, branch_taken}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Table: back-to-back accepts, each result checked one cycle later
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      drive(vecs[i].am, vecs[i].ur, vecs[i].sf, vecs[i].opc, vecs[i].cc,
            vecs[i].a, vecs[i].b, vecs[i].im);
      #1;
      chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("v%0d_result", i), result, vecs[i].exp_res);
      chk($sformatf("v%0d_taken", i), {31'd0, branch_taken}, {31'd0, vecs[i].exp_tk});
      chk($sformatf("v%0d_flags", i), {28'd0, flags}, {28'd0, vecs[i].exp_fl});
    end

    // Iterative shifts: latency = min(amount, 32) + 1
    idle();
    run_shift("lsl4", OP_LSL, 32'h0000_0001, 16'd4, 32'h0000_0010, 5);
    run_shift("lsl40", OP_LSL, 32'h0000_0001, 16'd40, 32'h0000_0000, 33);
    run_shift("lsr31", OP_LSR, 32'h8000_0000, 16'd31, 32'h0000_0001, 32);
    run_shift("lsr32", OP_LSR, 32'hFFFF_FFFF, 16'd32, 32'h0000_0000, 33);

    // Backpressure: result held while out_ready low, then back-to-back reload
    idle();
    drive(1'b0, 1'b0, 1'b0, OP_MOV, CC_EQ, 32'h0, 32'h0, 16'h00A5);
    out_ready = 1'b0;
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, OP_MOV, CC_EQ, 32'h0, 32'h0, 16'h005A);
    chk("bp_first", result, 32'h0000_00A5);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_valid_%0d", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("bp_result_%0d", k), result, 32'h0000_00A5);
      chk($sformatf("bp_in_ready_%0d", k), {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_ready_on_consume", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_reload_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_reload_result", result, 32'h0000_005A);

    // Reset in the middle of an 8-bit LSR aborts it and clears state
    idle();
    drive(1'b1, 1'b1, 1'b1, ALU_ADD, CC_EQ, 32'h7FFF_FFFF, 32'h0000_0001, 16'h0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_rst_flags", {28'd0, flags}, 32'h9);
    drive(1'b0, 1'b0, 1'b0, OP_LSR, CC_EQ, 32'h0000_00FF, 32'h0, 16'd8);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mid_busy_c1", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_flags", {28'd0, flags}, 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (out_valid || busy) seen = 1'b1;
    end
    chk("abort_no_delivery", {31'd0, seen}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
